// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports plus the memory-side bus.
// slave  : the arbiter's view (takes requests, drives acks and the memory bus).
// master : the environment's view (requesters and the memory device).
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
);
  // Requester 0 (CPU)
  logic          req0;
  logic [AW-1:0] addr0;
  logic          we0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;
  // Requester 1 (DMA/loader)
  logic          req1;
  logic [AW-1:0] addr1;
  logic          we1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;
  // Memory side
  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic          mem_drive;
  logic [DW-1:0] mem_din;
  // Status
  logic          busy;
  logic          owner;

  modport slave (
    input  req0, addr0, we0, wdata0,
    input  req1, addr1, we1, wdata1,
    input  mem_din,
    output ack0, rdata0, ack1, rdata1,
    output mem_a, mem_we, mem_dout, mem_drive,
    output busy, owner
  );

  modport master (
    output req0, addr0, we0, wdata0,
    output req1, addr1, we1, wdata1,
    output mem_din,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_a, mem_we, mem_dout, mem_drive,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> ACCESS -> ACK, one
// transaction per three cycles. Memory outputs come only from latched state,
// never combinationally from requester inputs.
// Build option: define MEM_ARBITER_RR_EN for round-robin tie-break; otherwise
// requester 0 wins every tie.
module mem_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          win;

  // Winner selection; only consulted in IDLE when at least one request is up.
  always_comb begin
    win = 1'b0;
    if (bus.req0 && bus.req1) begin
`ifdef MEM_ARBITER_RR_EN
      win = ~owner_q;
`else
      win = 1'b0;
`endif
    end else if (bus.req1) begin
      win = 1'b1;
    end
  end

  // Next-state logic and transaction latching.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          state_d = StAccess;
          owner_d = win;
          we_d    = win ? bus.we1    : bus.we0;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
        end
      end
      StAccess: state_d = StAck;
      StAck:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b1;  // so requester 0 takes the first tie
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read data capture at the edge leaving ACCESS; writes leave rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == StAccess && !we_q) begin
      if (owner_q) rdata1_q <= bus.mem_din;
      else         rdata0_q <= bus.mem_din;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.mem_a     = addr_q;
    bus.mem_dout  = wdata_q;
    bus.mem_we    = (state_q == StAccess) && we_q;
    bus.mem_drive = (state_q == StAccess) && we_q;
    bus.busy      = (state_q != StIdle);
    bus.ack0      = (state_q == StAck) && !owner_q;
    bus.ack1      = (state_q == StAck) && owner_q;
    bus.owner     = owner_q;
    bus.rdata0    = rdata0_q;
    bus.rdata1    = rdata1_q;
  end

endmodule
